// File: rtl/lookup_arbiter.sv
// Round-robin arbiter sharing one combinational table-lookup port between two requesters.
// Optional LOOKUP_ARBITER_BOUNDS_CHECK_EN answers out-of-range indices with None and skips the table.
module lookup_arbiter #(
  parameter int unsigned IDX_W       = 16,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned TABLE_DEPTH = 3
) (
  input  logic              _i_clk,
  input  logic              _i_rst,
  input  logic              _i_req0_valid,
  input  logic [IDX_W-1:0]  _i_req0_index,
  output logic              _o_req0_ready,
  input  logic              _i_req1_valid,
  input  logic [IDX_W-1:0]  _i_req1_index,
  output logic              _o_req1_ready,
  output logic [IDX_W-1:0]  _o_lut_index,
  input  logic [DATA_W:0]   _i_lut_result,
  output logic              _o_resp_valid,
  output logic              _o_resp_id,
  output logic [DATA_W:0]   _o_resp_data,
  input  logic              _i_resp_ready,
  output logic              _o_busy,
  output logic [7:0]        _o_none_count
);

  typedef enum logic [1:0] {StIdle, StLookup, StResp} state_e;

  state_e             state_q, state_d;
  logic               rr_q, rr_d;  // 0 prefers req0, 1 prefers req1
  logic [IDX_W-1:0]   lut_index_q, lut_index_d;
  logic               resp_id_q, resp_id_d;
  logic [DATA_W:0]    resp_data_q, resp_data_d;
  logic [7:0]         none_count_q, none_count_d;

  logic               grant0, grant1, in_idle, accept, win_id, oob;
  logic [IDX_W-1:0]   win_index;

  assign grant0    = _i_req0_valid && (!_i_req1_valid || !rr_q);
  assign grant1    = _i_req1_valid && (!_i_req0_valid || rr_q);
  // Readies are gated by reset so nothing is offered while reset is held.
  assign in_idle   = (state_q == StIdle) && !_i_rst;
  assign accept    = in_idle && (grant0 || grant1);
  assign win_id    = grant1;
  assign win_index = grant1 ? _i_req1_index : _i_req0_index;

`ifdef LOOKUP_ARBITER_BOUNDS_CHECK_EN
  localparam logic [IDX_W-1:0] DepthIdx = IDX_W'(TABLE_DEPTH);
  assign oob = (win_index >= DepthIdx);
`else
  assign oob = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    lut_index_d  = lut_index_q;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
    none_count_d = none_count_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          lut_index_d = win_index;
          resp_id_d   = win_id;
          rr_d        = ~win_id;
          if (oob) begin
            resp_data_d = {1'b1, {DATA_W{1'b0}}};
            state_d     = StResp;
          end else begin
            state_d     = StLookup;
          end
        end
      end
      StLookup: begin
        resp_data_d = _i_lut_result;
        state_d     = StResp;
      end
      StResp: begin
        if (_i_resp_ready) begin
          state_d = StIdle;
          if (resp_data_q[DATA_W] && (none_count_q != 8'hFF)) begin
            none_count_d = none_count_q + 8'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge _i_clk or posedge _i_rst) begin
    if (_i_rst) begin
      state_q      <= StIdle;
      rr_q         <= 1'b0;
      lut_index_q  <= '0;
      resp_id_q    <= 1'b0;
      resp_data_q  <= '0;
      none_count_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      lut_index_q  <= lut_index_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
      none_count_q <= none_count_d;
    end
  end

  assign _o_req0_ready = in_idle && grant0;
  assign _o_req1_ready = in_idle && grant1;
  assign _o_lut_index  = lut_index_q;
  assign _o_resp_valid = (state_q == StResp);
  assign _o_resp_id    = resp_id_q;
  assign _o_resp_data  = resp_data_q;
  assign _o_busy       = (state_q != StIdle);
  assign _o_none_count = none_count_q;

endmodule

// File: tb/tb_lookup_arbiter.sv
// Directed bench for lookup_arbiter with a 3-entry constant table (0->11, 1->12, 2->13, else None).
module tb_lookup_arbiter;

  logic        clk, rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [15:0] req0_index, req1_index, lut_index;
  logic [16:0] lut_result, resp_data;
  logic        resp_valid, resp_id, resp_ready, busy;
  logic [7:0]  none_count;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int acc_id[$];
  int acc_cyc[$];
  int rsp_id[$];
  logic [16:0] rsp_data[$];

  lookup_arbiter dut (
    ._i_clk        (clk),
    ._i_rst        (rst),
    ._i_req0_valid (req0_valid),
    ._i_req0_index (req0_index),
    ._o_req0_ready (req0_ready),
    ._i_req1_valid (req1_valid),
    ._i_req1_index (req1_index),
    ._o_req1_ready (req1_ready),
    ._o_lut_index  (lut_index),
    ._i_lut_result (lut_result),
    ._o_resp_valid (resp_valid),
    ._o_resp_id    (resp_id),
    ._o_resp_data  (resp_data),
    ._i_resp_ready (resp_ready),
    ._o_busy       (busy),
    ._o_none_count (none_count)
  );

  always_comb begin
    case (lut_index)
      16'd0:   lut_result = {1'b0, 16'd11};
      16'd1:   lut_result = {1'b0, 16'd12};
      16'd2:   lut_result = {1'b0, 16'd13};
      default: lut_result = {1'b1, 16'd0};
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake log, sampled at the active edge before the DUT state moves.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (req0_valid && req0_ready) begin acc_id.push_back(0); acc_cyc.push_back(cyc); end
    if (req1_valid && req1_ready) begin acc_id.push_back(1); acc_cyc.push_back(cyc); end
    if (resp_valid && resp_ready) begin
      rsp_id.push_back(int'(resp_id));
      rsp_data.push_back(resp_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    acc_id.delete();
    acc_cyc.delete();
    rsp_id.delete();
    rsp_data.delete();
  endtask

  task automatic wait_accept(input int n, input string tag);
    int k;
    k = 0;
    while (acc_id.size() < n && k < 50) begin
      step();
      k++;
    end
    check(tag, 32'(acc_id.size() >= n), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    req0_index = 16'd0; req1_index = 16'd0; resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    check("rst_ready0", 32'(req0_ready), 0);
    check("rst_ready1", 32'(req1_ready), 0);
    check("rst_lut_index", 32'(lut_index), 0);
    check("rst_resp_valid", 32'(resp_valid), 0);
    check("rst_resp_id", 32'(resp_id), 0);
    check("rst_resp_data", 32'(resp_data), 0);
    check("rst_none_count", 32'(none_count), 0);
    check("rst_busy", 32'(busy), 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;

    // Single lookup
    clear_logs();
    req0_valid = 1'b1; req0_index = 16'd1;
    #1;
    check("a_ready0", 32'(req0_ready), 1);
    check("a_ready1", 32'(req1_ready), 0);
    step();
    req0_valid = 1'b0;
    check("a_busy_lookup", 32'(busy), 1);
    check("a_lut_index", 32'(lut_index), 1);
    check("a_valid_early", 32'(resp_valid), 0);
    step();
    check("a_resp_valid", 32'(resp_valid), 1);
    check("a_resp_id", 32'(resp_id), 0);
    check("a_resp_data", 32'(resp_data), 32'h0000C);
    check("a_busy_resp", 32'(busy), 1);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check("a_busy_done", 32'(busy), 0);
    check("a_resp_gone", 32'(resp_valid), 0);

    // Contention from reset
    rst = 1'b1;
    #1;
    clear_logs();
    req0_valid = 1'b1; req0_index = 16'd0;
    req1_valid = 1'b1; req1_index = 16'd2;
    resp_ready = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 30 && rsp_id.size() < 2; k++) begin
      step();
      if (acc_id.size() >= 2) begin req0_valid = 1'b0; req1_valid = 1'b0; end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("b_resp_count", 32'(rsp_id.size()), 2);
    if (rsp_id.size() >= 2 && acc_id.size() >= 2) begin
      check("b_first_id", 32'(acc_id[0]), 0);
      check("b_second_id", 32'(acc_id[1]), 1);
      check("b_spacing", 32'(acc_cyc[1] - acc_cyc[0]), 3);
      check("b_data0", 32'(rsp_data[0]), 32'h0000B);
      check("b_data1", 32'(rsp_data[1]), 32'h0000D);
      check("b_rid0", 32'(rsp_id[0]), 0);
      check("b_rid1", 32'(rsp_id[1]), 1);
    end

    // Fairness with both requesters held valid
    clear_logs();
    req0_valid = 1'b1; req0_index = 16'd0;
    req1_valid = 1'b1; req1_index = 16'd1;
    resp_ready = 1'b1;
    for (int k = 0; k < 60 && acc_id.size() < 6; k++) step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int k = 0; k < 10 && busy; k++) step();
    check("c_accepts", 32'(acc_id.size()), 6);
    check("c_resps", 32'(rsp_id.size()), 6);
    if (acc_id.size() >= 6 && rsp_data.size() >= 6) begin
      for (int i = 0; i < 6; i++) begin
        check($sformatf("c_order%0d", i), 32'(acc_id[i]), 32'(i % 2));
        check($sformatf("c_data%0d", i), 32'(rsp_data[i]),
              (i % 2 == 1) ? 32'h0000C : 32'h0000B);
      end
    end

    // Backpressure
    clear_logs();
    resp_ready = 1'b0;
    req1_valid = 1'b1; req1_index = 16'd2;
    wait_accept(1, "d_accept");
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_index = 16'd0;
    step();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("d_valid%0d", k), 32'(resp_valid), 1);
      check($sformatf("d_data%0d", k), 32'(resp_data), 32'h0000D);
      check($sformatf("d_id%0d", k), 32'(resp_id), 1);
      check($sformatf("d_ready0_%0d", k), 32'(req0_ready), 0);
      step();
    end
    check("d_no_new_accept", 32'(acc_id.size()), 1);
    req0_valid = 1'b0;
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check("d_busy_done", 32'(busy), 0);
    check("d_none_count", 32'(none_count), 0);

    // Out-of-range index
    clear_logs();
    req0_valid = 1'b1; req0_index = 16'd5;
    wait_accept(1, "e_accept");
    req0_valid = 1'b0;
    check("e_lut_index", 32'(lut_index), 5);
`ifdef LOOKUP_ARBITER_BOUNDS_CHECK_EN
    check("e_valid_lat1", 32'(resp_valid), 1);
`else
    check("e_valid_lat1", 32'(resp_valid), 0);
    step();
`endif
    check("e_resp_valid", 32'(resp_valid), 1);
    check("e_resp_data", 32'(resp_data), 32'h10000);
    check("e_resp_id", 32'(resp_id), 0);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check("e_none_count", 32'(none_count), 1);

    // Reset while in LOOKUP
    clear_logs();
    req0_valid = 1'b1; req0_index = 16'd2;
    wait_accept(1, "f_accept");
    req0_valid = 1'b0;
    check("f_in_lookup", 32'(busy), 1);
    check("f_valid_lookup", 32'(resp_valid), 0);
    rst = 1'b1;
    #1;
    check("f_busy_rst", 32'(busy), 0);
    check("f_lut_rst", 32'(lut_index), 0);
    check("f_valid_rst", 32'(resp_valid), 0);
    check("f_data_rst", 32'(resp_data), 0);
    check("f_none_rst", 32'(none_count), 0);
    step();
    rst = 1'b0;
    resp_ready = 1'b1;
    repeat (4) step();
    check("f_no_resp", 32'(rsp_id.size()), 0);
    req1_valid = 1'b1; req1_index = 16'd0;
    wait_accept(2, "f_accept2");
    req1_valid = 1'b0;
    for (int k = 0; k < 10 && rsp_id.size() < 1; k++) step();
    check("f_resp_count", 32'(rsp_id.size()), 1);
    if (rsp_id.size() >= 1) begin
      check("f_resp_id", 32'(rsp_id[0]), 1);
      check("f_resp_data", 32'(rsp_data[0]), 32'h0000B);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lookup_arbiter.md
Name: lookup_arbiter

Overview:
- Shares one combinational indexed-table lookup port between two requesters. The table returns an Option of a 16-bit value.
- Grants one requester at a time with round-robin fairness and drives the table index from a register.
- Captures the Option result and returns it to the winner over a valid/ready response channel.
- Sits between client pipelines and a single array-lookup unit, e.g. a 3-entry constant table.

Parameters:
- IDX_W, 16, width of the lookup index.
- DATA_W, 16, payload width. Result width is DATA_W+1.
- TABLE_DEPTH, 3, number of valid table entries. Used only by the optional feature.

Ports:
- _i_clk  input  1  clock, rising edge.
- _i_rst  input  1  asynchronous reset, active-high.
- _i_req0_valid  input  1  requester 0 has a lookup.
- _i_req0_index  input  IDX_W  requester 0 index.
- _o_req0_ready  output  1  requester 0 accepted this cycle.
- _i_req1_valid  input  1  requester 1 has a lookup.
- _i_req1_index  input  IDX_W  requester 1 index.
- _o_req1_ready  output  1  requester 1 accepted this cycle.
- _o_lut_index  output  IDX_W  index to shared table.
- _i_lut_result  input  DATA_W+1  table result, combinational from _o_lut_index.
- _o_resp_valid  output  1  response available.
- _o_resp_id  output  1  requester that owns the response.
- _o_resp_data  output  DATA_W+1  Option result.
- _i_resp_ready  input  1  consumer takes the response.
- _o_busy  output  1  state is not IDLE.
- _o_none_count  output  8  saturating count of None responses delivered.

Behaviour:
- Option encoding: bit [DATA_W] is the tag. 0 = Some, 1 = None. Bits [DATA_W-1:0] are the payload; the payload is don't-care when the tag is None.
- Reset values: state IDLE, rr pointer 0 (req0 preferred), and _o_lut_index, _o_resp_valid, _o_resp_id, _o_resp_data, _o_none_count all 0. Both ready outputs are 0 during reset.
- FSM states: IDLE, LOOKUP, RESP.
- IDLE, arbitration:
  - Grant goes to the single valid requester.
  - If both are valid, grant goes to the requester the rr pointer prefers.
  - Ready is asserted combinationally, only to the granted requester, only in IDLE.
- IDLE, accept (valid&&ready):
  - Register the index into _o_lut_index and the owner id.
  - Set the rr pointer to prefer the other requester.
  - Move to LOOKUP.
- IDLE with no valid requester: stay in IDLE, pointer unchanged.
- LOOKUP:
  - _o_lut_index holds the latched index. _i_lut_result is sampled at the end of this cycle into the response register.
  - Move to RESP.
- RESP:
  - _o_resp_valid=1. _o_resp_id and _o_resp_data are held stable until _i_resp_ready.
  - On handshake: move to IDLE, and increment _o_none_count if the tag is 1 (saturates at 255).
  - Both ready outputs are 0 throughout RESP and LOOKUP.
- Latency: response valid 2 cycles after the accept edge. Minimum spacing between accepts is 3 cycles.
- _o_lut_index holds its last value outside LOOKUP. It changes only on accept.
- Requester inputs are ignored while not in IDLE. A requester may hold valid; it will be granted later.
- Reset mid-operation: the in-flight transaction is discarded, no response is produced, and all state returns to reset values immediately (asynchronous).

Optional Feature:
- Macro LOOKUP_ARBITER_BOUNDS_CHECK_EN.
- Defined:
  - On accept, an index >= TABLE_DEPTH skips LOOKUP and goes straight to RESP.
  - Response data is None: tag 1, payload 0.
  - Latency is 1 cycle. _o_lut_index is still updated.
- Undefined: every index goes through LOOKUP, and the table result is returned verbatim.

Test Plan:
- Table contents are index 0→11, 1→12, 2→13, otherwise None.
- Single lookup:
  - Stimulus: req0 index 1.
  - Response: 2 cycles after accept, _o_resp_valid=1, _o_resp_id=0, _o_resp_data=17'h0000C; busy falls after the resp_ready handshake.
- Contention:
  - Stimulus: req0 index 0 and req1 index 2 valid together from reset, resp_ready=1.
  - Response: req0 served first with 17'h0000B, then req1 with 17'h0000D. req1 accept occurs exactly 3 cycles after req0 accept.
- Fairness:
  - Stimulus: both requesters held valid continuously for 6 accepts.
  - Response: grant order 0,1,0,1,0,1.
- Backpressure:
  - Stimulus: resp_ready=0 for 5 cycles after a response with req1 index 2.
  - Response: _o_resp_data stays 17'h0000D and resp_id stays 1. No new accept occurs while waiting, even with req0 valid.
- Out-of-range:
  - Stimulus: req0 index 5.
  - Response with macro: None 17'h10000, 1 cycle after accept.
  - Response without macro: 2 cycles after accept, the table's None passes through with tag 1.
  - Either way _o_none_count increments to 1.
- Reset in LOOKUP:
  - Stimulus: assert _i_rst for one cycle in LOOKUP.
  - Response: no response is ever produced, outputs read zero, and the next req1 index 0 returns 17'h0000B normally.
